// File: rtl/multi_race_observer.sv
// multi_race_observer
//   N-channel four-phase handshake responder with a shared first-finisher
//   arbiter. Each channel sees start rise, waits a fixed or pseudo-random
//   delay, raises done, and drops done once start falls. The arbiter latches
//   the lowest-indexed channel that finished first since reset or the last
//   clear_winner.
//
// Handshake (per channel, four-phase): start[i] high requests; done[i] rises
//   after the delay and stays high while start[i] stays high; start[i] low
//   returns the channel to IDLE and done[i] falls on that edge. Dropping
//   start[i] before done rises aborts the request.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   [N_CH-1:0] per-channel request level
//   mode         in   0 = fixed delay, 1 = random delay (sampled at load)
//   delay        in   [CNT_W-1:0] fixed delay (sampled at load)
//   clear_winner in   discard the latched winner
//   done         out  [N_CH-1:0] per-channel acknowledge, registered
//   winner_valid out  a winner is latched
//   winner_id    out  index of the first channel to finish
//   state_dbg    out  [2*N_CH-1:0] per-channel FSM state, 2 bits each
//                     (0 = IDLE, 1 = WAIT, 2 = DONE)
module multi_race_observer #(
  parameter int          N_CH      = 4,
  parameter int          CNT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     start,
  input  logic                mode,
  input  logic [CNT_W-1:0]    delay,
  input  logic                clear_winner,
  output logic [N_CH-1:0]     done,
  output logic                winner_valid,
  output logic [ID_W-1:0]     winner_id,
  output logic [2*N_CH-1:0]   state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q [N_CH];
  state_e             state_d [N_CH];
  logic [CNT_W-1:0]   cnt_q   [N_CH];
  logic [CNT_W-1:0]   cnt_d   [N_CH];
  logic [N_CH-1:0]    done_q, done_d;
  logic [N_CH-1:0]    finish;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               winner_valid_q, winner_valid_d;
  logic [ID_W-1:0]    winner_id_q, winner_id_d;
  logic [ID_W-1:0]    first_id;

  // Channel FSMs and shared Galois LFSR (taps 0xB400, shifts right).
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    done_d = done_q;
    finish = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          done_d[i] = 1'b0;
          if (start[i]) begin
            // All channels loading on one edge see the same LFSR value.
            cnt_d[i]   = mode ? lfsr_q[CNT_W-1:0] : delay;
            state_d[i] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          done_d[i] = 1'b0;
          // Abort wins over an expiring count.
          if (!start[i]) begin
            state_d[i] = ST_IDLE;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_DONE;
            done_d[i]  = 1'b1;
            finish[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_DONE: begin
          done_d[i] = 1'b1;
          if (!start[i]) begin
            state_d[i] = ST_IDLE;
            done_d[i]  = 1'b0;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          done_d[i]  = 1'b0;
        end
      endcase
    end
  end

  // Winner arbiter: lowest finishing index wins; a clear on the same edge as
  // a finish replaces the old winner instead of leaving the latch empty.
  always_comb begin
    first_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (finish[i]) first_id = ID_W'(i);
    end
    winner_valid_d = winner_valid_q;
    winner_id_d    = winner_id_q;
    if ((finish != '0) && (!winner_valid_q || clear_winner)) begin
      winner_valid_d = 1'b1;
      winner_id_d    = first_id;
    end else if (clear_winner) begin
      winner_valid_d = 1'b0;
      winner_id_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      done_q         <= '0;
      lfsr_q         <= LFSR_SEED;
      winner_valid_q <= 1'b0;
      winner_id_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      done_q         <= done_d;
      lfsr_q         <= lfsr_d;
      winner_valid_q <= winner_valid_d;
      winner_id_q    <= winner_id_d;
    end
  end

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_dbg[2*i +: 2] = state_q[i];
    end
  end

  assign done         = done_q;
  assign winner_valid = winner_valid_q;
  assign winner_id    = winner_id_q;

endmodule

// File: tb/tb_multi_race_observer.sv
// Bench for multi_race_observer: directed handshake/arbiter scenarios plus
// randomized requests, checked every cycle against a timestamp-based model.
module tb_multi_race_observer;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int ID_W  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic [N_CH-1:0]     start = '0;
  logic                mode = 1'b0;
  logic [CNT_W-1:0]    delay = '0;
  logic                clear_winner = 1'b0;
  logic [N_CH-1:0]     done;
  logic                winner_valid;
  logic [ID_W-1:0]     winner_id;
  logic [2*N_CH-1:0]   state_dbg;

  multi_race_observer #(.N_CH(N_CH), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .delay(delay),
    .clear_winner(clear_winner), .done(done), .winner_valid(winner_valid),
    .winner_id(winner_id), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each request is tracked by the absolute edge number at which done must
  // rise: load edge + delay + 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  int              edge_n = 0;
  logic [N_CH-1:0] m_done = '0;
  logic [N_CH-1:0] m_busy = '0;
  int              m_due [N_CH];
  logic            m_valid = 1'b0;
  int              m_id = 0;
  logic [15:0]     m_lfsr = 16'hACE1;
  int              n_loads = 0;

  always @(posedge clk) begin
    logic [N_CH-1:0] fin;
    edge_n++;
    if (rst) begin
      m_done = '0; m_busy = '0; m_valid = 1'b0; m_id = 0; m_lfsr = 16'hACE1;
    end else begin
      fin = '0;
      for (int i = 0; i < N_CH; i++) begin
        if (m_done[i]) begin
          if (!start[i]) m_done[i] = 1'b0;
        end else if (m_busy[i]) begin
          if (!start[i]) m_busy[i] = 1'b0;
          else if (edge_n == m_due[i]) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b1; fin[i] = 1'b1;
          end
        end else if (start[i]) begin
          m_busy[i] = 1'b1;
          m_due[i]  = edge_n + 1 + (mode ? int'(m_lfsr) % (1 << CNT_W) : int'(delay));
          n_loads++;
        end
      end
      if (fin != '0 && (!m_valid || clear_winner)) begin
        m_valid = 1'b1;
        m_id = 0;
        while (!fin[m_id]) m_id++;
      end else if (clear_winner) begin
        m_valid = 1'b0; m_id = 0;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("done", 32'(done), 32'(m_done));
      chk("winner_valid", 32'(winner_valid), 32'(m_valid));
      if (m_valid) chk("winner_id", 32'(winner_id), 32'(m_id));
      else         chk("winner_id_idle", 32'(winner_id), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_winner = 1'b1; tick(); clear_winner = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] lv;
    int cyc;

    // Pin the model LFSR against hand-computed values.
    lv = 16'hACE1; lv = lfsr_step(lv);
    chk("lfsr_step1", 32'(lv), 32'h0000E270);
    lv = lfsr_step(lv);
    chk("lfsr_step2", 32'(lv), 32'h00007138);

    tick(3);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(winner_valid), 32'd0);
    chk("rst_id", 32'(winner_id), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    check_en = 1;

    // 1: fixed delay 5 on ch0 -> done after 7th negedge (edge k+6)
    mode = 1'b0; delay = 8'd5; start = 4'b0001;
    tick(6);
    chk("t1_done_early", 32'(done[0]), 32'd0);
    tick();
    chk("t1_done", 32'(done[0]), 32'd1);
    chk("t1_valid", 32'(winner_valid), 32'd1);
    chk("t1_id", 32'(winner_id), 32'd0);
    start = 4'b0000; tick();
    chk("t1_done_fall", 32'(done[0]), 32'd0);
    tick();

    // 2: ch1 and ch2 together, delay 3 -> lowest index wins
    pulse_clear();
    chk("t2_cleared", 32'(winner_valid), 32'd0);
    delay = 8'd3; start = 4'b0110;
    tick(4);
    chk("t2_done_early", 32'(done), 32'd0);
    tick();
    chk("t2_done", 32'(done), 32'b0110);
    chk("t2_id", 32'(winner_id), 32'd1);
    delay = 8'd0; start = 4'b1110;
    tick(2);
    chk("t2_done3", 32'(done), 32'b1110);
    chk("t2_id_kept", 32'(winner_id), 32'd1);
    start = 4'b0000; tick(2);

    // 6: clear on the same edge as ch3 finishes, with winner 1 latched
    delay = 8'd0; start = 4'b1000;
    tick();
    clear_winner = 1'b1;
    tick();
    clear_winner = 1'b0;
    chk("t6_valid", 32'(winner_valid), 32'd1);
    chk("t6_id", 32'(winner_id), 32'd3);
    start = 4'b0000; tick(2);
    pulse_clear();
    chk("t6_clr_valid", 32'(winner_valid), 32'd0);
    chk("t6_clr_id", 32'(winner_id), 32'd0);

    // 3: abort after 4 edges, then a short request
    delay = 8'd10; start = 4'b0001;
    tick(4);
    start = 4'b0000; tick();
    chk("t3_abort_done", 32'(done[0]), 32'd0);
    chk("t3_abort_idle", 32'(state_dbg[1:0]), 32'd0);
    chk("t3_abort_valid", 32'(winner_valid), 32'd0);
    delay = 8'd2; start = 4'b0001;
    tick(3);
    chk("t3_done_early", 32'(done[0]), 32'd0);
    tick();
    chk("t3_done", 32'(done[0]), 32'd1);
    start = 4'b0000; tick(2);

    // 5: reset with ch1 in DONE and ch0 in WAIT
    pulse_clear();
    delay = 8'd0; start = 4'b0010;
    tick(2);
    delay = 8'd20; start = 4'b0011;
    tick();
    chk("t5_pre_state", 32'(state_dbg[3:0]), 32'b1001);
    rst = 1'b1; tick();
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_valid", 32'(winner_valid), 32'd0);
    chk("t5_rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0; tick();
    chk("t5_reload", 32'(state_dbg), 32'b0101);
    start = 4'b0000; tick(2);

    // 4: randomized requests, mostly random-delay mode
    n_loads = 0; cyc = 0;
    while (n_loads < 1000 && cyc < 60000) begin
      for (int i = 0; i < N_CH; i++) begin
        if (start[i]) begin
          if (m_done[i] && $urandom_range(0, 3) == 0) start[i] = 1'b0;
          else if (!m_done[i] && $urandom_range(0, 299) == 0) start[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          start[i] = 1'b1;
        end
      end
      mode = ($urandom_range(0, 3) != 0);
      delay = CNT_W'($urandom_range(0, 15));
      clear_winner = ($urandom_range(0, 19) == 0);
      tick();
      cyc++;
    end
    clear_winner = 1'b0;
    chk("t4_requests", 32'(n_loads >= 1000), 32'd1);
    start = 4'b0000; tick(3);

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
